// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller.
// Turns the per-stage stall requests into the 6-bit stall vector
// (bit0 PC .. bit5 WB) and converts a taken branch reported by EX into a
// one-cycle flush + PC redirect.
// A branch that arrives while fetch is busy is parked in BR_WAIT until
// the fetch finishes; the redirect is then issued.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall/flush performance
// counters. Without it both counter outputs are tied to zero.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        pc_load,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

    state_t      state;
    logic [31:0] pending_pc;
    logic        accept;
    logic        accept_now;
    logic        release_br;

    // Stall vector: deepest requester wins; BR_WAIT keeps EX fed with bubbles
    always_comb begin
        stall = 6'b000000;
        if (rst)                 stall = 6'b000000;
        else if (stallreq_mem)   stall = 6'b011111;
        else if (stallreq_ex)    stall = 6'b001111;
        else if (stallreq_id)    stall = 6'b000111;
        else if (state == BR_WAIT) stall = 6'b000111;
        else if (stallreq_if)    stall = 6'b000011;
    end

    // Branch acceptance and redirect generation; all zero-latency
    always_comb begin
        // A held EX re-presents its branch later, so ignoring it here is safe
        accept     = !rst && branch_flag_i && (state == RUN) && !stall[3];
        accept_now = accept && !stallreq_if;
        // Parked redirect fires once fetch is idle and EX/MEM are moving
        release_br = !rst && (state == BR_WAIT) && !stallreq_if
                     && !stallreq_ex && !stallreq_mem;
        pc_load    = accept_now || release_br;
        flush      = pc_load;
        new_pc     = 32'h0;
        if (release_br)      new_pc = pending_pc;
        else if (accept_now) new_pc = branch_target_i;
    end

    // FSM: park the target while fetch is busy, return to RUN after redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pending_pc <= 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (accept && stallreq_if) begin
                        pending_pc <= branch_target_i;
                        state      <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (release_br) begin
                        pending_pc <= 32'h0;
                        state      <= RUN;
                    end
                end
                default: begin
                    state      <= RUN;
                    pending_pc <= 32'h0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Performance counters: PC-held cycles and flush pulses, wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (stall[0]) stall_cnt <= stall_cnt + 32'd1;
            if (flush)    flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl.
// Stimulus pushes the hand-computed expected outputs for each cycle; a
// monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [5:0]  stall;
    logic        flush, pc_load;
    logic [31:0] new_pc, stall_cnt_o, flush_cnt_o;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        pc_load;
        logic [31:0] new_pc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .stall(stall), .flush(flush), .pc_load(pc_load), .new_pc(new_pc),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per driven cycle, checked mid-cycle
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (stall !== e.stall || flush !== e.flush ||
                pc_load !== e.pc_load || new_pc !== e.new_pc) begin
                fails++;
                $display("FAIL cyc%0d outputs: got stall=%b flush=%b pc_load=%b new_pc=%h, want stall=%b flush=%b pc_load=%b new_pc=%h",
                         cyc, stall, flush, pc_load, new_pc,
                         e.stall, e.flush, e.pc_load, e.new_pc);
            end
        end
    end

    // Drive one cycle of inputs and record what the outputs must be
    task automatic step(input logic r, input logic i, input logic d,
                        input logic x, input logic m, input logic b,
                        input logic [31:0] t, input logic [5:0] es,
                        input logic ef, input logic [31:0] epc);
        exp_t e;
        rst = r; stallreq_if = i; stallreq_id = d; stallreq_ex = x;
        stallreq_mem = m; branch_flag_i = b; branch_target_i = t;
        e.stall = es; e.flush = ef; e.pc_load = ef; e.new_pc = epc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] es);
        step(0, 0, 0, 0, 0, 0, 32'h0, es, 0, 32'h0);
    endtask

    task automatic check_cnt(input string name, input logic [31:0] got,
                             input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        logic [31:0] want_sc, want_fc;
        @(posedge clk); #1;
        // Reset dominates every input
        step(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 6'b000000, 0, 32'h0);
        step(1, 0, 0, 0, 1, 1, 32'h1234_5678, 6'b000000, 0, 32'h0);
        idle(6'b000000);
        // Stall priority
        step(0, 0, 1, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0);
        step(0, 1, 1, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
        step(0, 1, 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0, 6'b000011, 0, 32'h0);
        // Zero-latency branch, then quiet
        step(0, 0, 0, 0, 0, 1, 32'h0000_1000, 6'b000000, 1, 32'h0000_1000);
        idle(6'b000000);
        // Branch while EX stalled is ignored, state stays RUN
        step(0, 0, 0, 1, 0, 1, 32'h0000_1800, 6'b001111, 0, 32'h0);
        idle(6'b000000);
        // Branch while MEM stalled is ignored too
        step(0, 0, 0, 0, 1, 1, 32'h0000_1900, 6'b011111, 0, 32'h0);
        idle(6'b000000);
        // ID stall does not block acceptance; flush leaves stall untouched
        step(0, 0, 1, 0, 0, 1, 32'h0000_5000, 6'b000111, 1, 32'h0000_5000);
        idle(6'b000000);
        // Branch with fetch busy: parked, 3 wait cycles, then redirect
        step(0, 1, 0, 0, 0, 1, 32'h0000_2040, 6'b000011, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
        step(0, 1, 0, 0, 0, 1, 32'h0000_3333, 6'b000111, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 6'b000111, 1, 32'h0000_2040);
        idle(6'b000000);
        // Parked redirect held back by EX stall
        step(0, 1, 0, 0, 0, 1, 32'h0000_3000, 6'b000011, 0, 32'h0);
        step(0, 0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 32'h0000_7777, 6'b000111, 1, 32'h0000_3000);
        idle(6'b000000);
        // Reset during BR_WAIT discards the pending redirect
        step(0, 1, 0, 0, 0, 1, 32'h0000_4000, 6'b000011, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
        idle(6'b000000);
        idle(6'b000000);
        // Counters: 5 fetch-stall cycles then one accepted branch
        step(1, 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
        for (int k = 0; k < 5; k++)
            step(0, 1, 0, 0, 0, 0, 32'h0, 6'b000011, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 32'h0000_6000, 6'b000000, 1, 32'h0000_6000);
`ifdef PIPE_CTRL_PERF_EN
        want_sc = 32'd5; want_fc = 32'd1;
`else
        want_sc = 32'd0; want_fc = 32'd0;
`endif
        check_cnt("stall_cnt", stall_cnt_o, want_sc);
        check_cnt("flush_cnt", flush_cnt_o, want_fc);
        idle(6'b000000);
        // Let the monitor drain, bounded
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset (`RstEnable = 1).
REQ-003 SHALL have stallreq_if, input, 1, IF stage busy (fetch in progress).
REQ-004 SHALL have stallreq_id, input, 1, ID stall request (load-use hazard).
REQ-005 SHALL have stallreq_ex, input, 1, EX stall request (multi-cycle op).
REQ-006 SHALL have stallreq_mem, input, 1, MEM stall request (memory access in progress).
REQ-007 SHALL have branch_flag_i, input, 1, EX reports taken branch/jump.
REQ-008 SHALL have branch_target_i, input, 32 (`RegBus), redirect address.
REQ-009 SHALL have stall, output, 6, per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop.
REQ-010 SHALL have flush, output, 1, squash IF/ID and ID/EX contents.
REQ-011 SHALL have pc_load, output, 1, PC loads new_pc this cycle.
REQ-012 SHALL have new_pc, output, 32, redirect address.
REQ-013 SHALL have stall_cnt_o and flush_cnt_o, outputs, 32 each, performance counters (see Configuration).

Function
REQ-014 SHALL compute stall combinationally, highest priority first: stallreq_mem -> 6'b011111; stallreq_ex -> 6'b001111; stallreq_id -> 6'b000111; state BR_WAIT -> 6'b000111; stallreq_if -> 6'b000011; else 6'b000000.
REQ-015 SHALL implement FSM states RUN and BR_WAIT; reset state RUN.
REQ-016 SHALL accept a branch only when branch_flag_i = 1, state = RUN and stall[3] = 0; otherwise ignore branch_flag_i (held EX re-presents it).
REQ-017 On acceptance with stallreq_if = 0: SHALL assert flush = 1, pc_load = 1, new_pc = branch_target_i in the same cycle (zero latency), stay in RUN.
REQ-018 On acceptance with stallreq_if = 1: SHALL latch branch_target_i into a pending register, go to BR_WAIT, flush = pc_load = 0 that cycle.
REQ-019 In BR_WAIT: SHALL hold pending target; first cycle with stallreq_if = 0 and stallreq_ex = stallreq_mem = 0 SHALL assert flush = pc_load = 1 for exactly one cycle with new_pc = pending target, then return to RUN.
REQ-020 In BR_WAIT the 6'b000111 pattern SHALL inject bubbles into EX so no wrong-path instruction executes; no second branch can be accepted.
REQ-021 flush and pc_load SHALL never be asserted for more than one consecutive cycle per accepted branch.
REQ-022 new_pc SHALL equal 32'h0 whenever pc_load = 0.
REQ-023 flush SHALL NOT alter stall; flush takes precedence over stall at IF/ID and ID/EX.

Reset
REQ-024 With rst = 1 at a clock edge: state SHALL become RUN, pending target 32'h0, counters 0; any pending redirect SHALL be discarded.
REQ-025 While rst = 1: stall = 6'b000000, flush = 0, pc_load = 0, new_pc = 32'h0, regardless of inputs.

Configuration
REQ-026 With PIPE_CTRL_PERF_EN defined: stall_cnt_o SHALL increment (wrapping at 2^32) every non-reset cycle with stall[0] = 1; flush_cnt_o SHALL increment every cycle with flush = 1.
REQ-027 Without PIPE_CTRL_PERF_EN: no counter registers SHALL exist; stall_cnt_o and flush_cnt_o SHALL be constant 32'h0.

Verification
REQ-028 stallreq_mem = 1 and stallreq_id = 1 simultaneously -> stall = 6'b011111.
REQ-029 branch_flag_i = 1, target 32'h0000_1000, all stallreq = 0 -> same cycle flush = 1, pc_load = 1, new_pc = 32'h0000_1000; next cycle both 0.
REQ-030 branch target 32'h0000_2040 with stallreq_if = 1 for 3 cycles -> stall = 6'b000111 for 3 cycles, flush/pc_load = 0; 4th cycle (stallreq_if = 0) flush = pc_load = 1, new_pc = 32'h0000_2040; then RUN.
REQ-031 branch_flag_i = 1 with stallreq_ex = 1 -> branch ignored, flush = 0, state RUN; stall = 6'b001111.
REQ-032 rst = 1 asserted during BR_WAIT -> next cycle after rst release no flush pulse, state RUN, stall = 6'b000000 with no requests.
REQ-033 PIPE_CTRL_PERF_EN defined, 5 cycles stallreq_if = 1 then one accepted branch -> stall_cnt_o = 5, flush_cnt_o = 1; undefined -> both 0.
